// File: rtl/mmio_led_chain_pkg.sv
// Shared definitions for the memory-mapped LED chain driver and sibling MMIO peripherals.
package mmio_pkg;

   localparam logic [31:0] DATA_ADDR_DEF   = 32'h0000_03fc;
   localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_03f8;
   localparam logic [31:0] CTRL_ADDR_DEF   = 32'h0000_03f4;

   localparam int T0H_DEF    = 10;
   localparam int T1H_DEF    = 20;
   localparam int TBIT_DEF   = 34;
   localparam int TRESET_DEF = 2000;

   localparam int PIX_BITS = 24;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_FULL    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      LATCH = 2'd2
   } led_state_t;

   function automatic int ch_width(input int channels);
      return (channels <= 1) ? 1 : $clog2(channels);
   endfunction

endpackage

// File: rtl/mmio_led_chain_if.sv
// CPU data bus slice seen by the LED chain driver: address, write strobe/data, status read-back.
interface mmio_led_chain_if;

   logic [31:0] addr;
   logic [31:0] w_data;
   logic        w_en;
   logic [31:0] r_data;
   logic        sel_hit;

   modport master (
      output addr,
      output w_data,
      output w_en,
      input  r_data,
      input  sel_hit
   );

   modport slave (
      input  addr,
      input  w_data,
      input  w_en,
      output r_data,
      output sel_hit
   );

endinterface

// File: rtl/mmio_led_chain_fifo.sv
// Generic synchronous FIFO with occupancy count; a pop and push in the same cycle are allowed when full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic [WIDTH-1:0]        i_wdata,
   output logic [WIDTH-1:0]        o_rdata,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // When full, the write slot equals the read slot; the pop reads the old word before the edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_led_chain.sv
// WS2812-style multi-channel LED chain driver on the cpu data bus.
// Pixels are queued in a FIFO, streamed back-to-back MSB-first, then closed with a latch gap.
//
//   state | meaning
//   IDLE  | all lines low, waiting for enable and a queued pixel
//   SEND  | shifting the current pixel out on its channel, one TBIT period per bit
//   LATCH | all lines low for TRESET cycles so the chain latches
module mmio_led_chain
   import mmio_pkg::*;
#(
   parameter int          CHANNELS    = 8,
   parameter int          DEPTH       = 4,
   parameter logic [31:0] DATA_ADDR   = DATA_ADDR_DEF,
   parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
   parameter logic [31:0] CTRL_ADDR   = CTRL_ADDR_DEF,
   parameter int          T0H         = T0H_DEF,
   parameter int          T1H         = T1H_DEF,
   parameter int          TBIT        = TBIT_DEF,
   parameter int          TRESET      = TRESET_DEF
) (
   input  logic                clock,
   input  logic                reset_n,
   mmio_led_chain_if.slave     bus,
   output logic [CHANNELS-1:0] led_out
);

   localparam int CH_W    = ch_width(CHANNELS);
   localparam int FIFO_W  = CH_W + PIX_BITS;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int CYC_MAX = (TBIT > TRESET) ? TBIT : TRESET;
   localparam int CYC_W   = $clog2(CYC_MAX);

   localparam logic [CYC_W-1:0] C_TBIT_END   = CYC_W'(TBIT - 1);
   localparam logic [CYC_W-1:0] C_TRESET_END = CYC_W'(TRESET - 1);
   localparam logic [CYC_W-1:0] C_T0H        = CYC_W'(T0H);
   localparam logic [CYC_W-1:0] C_T1H        = CYC_W'(T1H);

   logic                w_sel_hit;
   logic                w_push_req;
   logic                w_ctrl_wr;
   logic                w_drop;
   logic                w_push_ok;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [CNT_W-1:0]    w_count;
   logic [7:0]          w_cnt8;
   logic [FIFO_W-1:0]   w_fifo_wdata;
   logic [FIFO_W-1:0]   w_fifo_rdata;
   logic [31:0]         w_status;

   led_state_t          r_state;
   led_state_t          w_state_nxt;
   logic [CYC_W-1:0]    r_cyc;
   logic [CYC_W-1:0]    w_cyc_nxt;
   logic [4:0]          r_bit_idx;
   logic [4:0]          w_bit_idx_nxt;
   logic [23:0]         r_shift;
   logic [23:0]         w_shift_nxt;
   logic [CH_W-1:0]     r_ch;
   logic [CH_W-1:0]     w_ch_nxt;
   logic [CYC_W-1:0]    w_thr;
   logic [CHANNELS-1:0] r_led;
   logic [CHANNELS-1:0] w_led_nxt;
   logic                r_enable;
   logic                r_overflow;

   assign w_sel_hit    = (bus.addr == STATUS_ADDR);
   assign w_push_req   = bus.w_en && (bus.addr == DATA_ADDR);
   assign w_ctrl_wr    = bus.w_en && (bus.addr == CTRL_ADDR);
   assign w_drop       = w_push_req && w_full && !w_pop;
   assign w_push_ok    = w_push_req && !w_drop;
   assign w_fifo_wdata = {bus.w_data[24 +: CH_W], bus.w_data[23:0]};

   sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_push  (w_push_ok),
      .i_pop   (w_pop),
      .i_wdata (w_fifo_wdata),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_cyc_nxt     = r_cyc;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_ch_nxt      = r_ch;
      w_pop         = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_enable && !w_empty) begin
               w_pop         = 1'b1;
               w_shift_nxt   = w_fifo_rdata[23:0];
               w_ch_nxt      = w_fifo_rdata[FIFO_W-1:24];
               w_bit_idx_nxt = 5'd23;
               w_cyc_nxt     = '0;
               w_state_nxt   = SEND;
            end
         end
         SEND: begin
            if (r_cyc == C_TBIT_END) begin
               w_cyc_nxt = '0;
               if (r_bit_idx != 5'd0) begin
                  w_shift_nxt   = {r_shift[22:0], 1'b0};
                  w_bit_idx_nxt = r_bit_idx - 5'd1;
               end else if (r_enable && !w_empty) begin
                  // next pixel starts on the very next cycle, no inter-pixel gap
                  w_pop         = 1'b1;
                  w_shift_nxt   = w_fifo_rdata[23:0];
                  w_ch_nxt      = w_fifo_rdata[FIFO_W-1:24];
                  w_bit_idx_nxt = 5'd23;
               end else begin
                  w_state_nxt = LATCH;
               end
            end else begin
               w_cyc_nxt = r_cyc + 1'b1;
            end
         end
         LATCH: begin
            if (r_cyc == C_TRESET_END) begin
               w_cyc_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               w_cyc_nxt = r_cyc + 1'b1;
            end
         end
         default: begin
            w_cyc_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Channel indices beyond CHANNELS match no line, so timing runs with all lines low.
   always_comb begin
      w_led_nxt = '0;
      w_thr     = r_shift[23] ? C_T1H : C_T0H;
      if ((r_state == SEND) && (r_cyc < w_thr)) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (r_ch == CH_W'(i)) begin
               w_led_nxt[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_cyc      <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_ch       <= '0;
         r_led      <= '0;
         r_enable   <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cyc     <= w_cyc_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_ch      <= w_ch_nxt;
         r_led     <= w_led_nxt;
         if (w_ctrl_wr) begin
            r_enable <= bus.w_data[0];
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (w_ctrl_wr && bus.w_data[1]) begin
            r_overflow <= 1'b0;
         end
      end
   end

   generate
      if (CNT_W > 8) begin : g_cnt_sat
         assign w_cnt8 = (w_count > CNT_W'(255)) ? 8'hFF : w_count[7:0];
      end else begin : g_cnt_ext
         assign w_cnt8 = 8'(w_count);
      end
   endgenerate

   always_comb begin
      w_status                         = '0;
      w_status[STAT_BUSY]              = (r_state != IDLE);
      w_status[STAT_EMPTY]             = w_empty;
      w_status[STAT_FULL]              = w_full;
      w_status[STAT_OVF]               = r_overflow;
      w_status[STAT_CNT_LSB +: 8]      = w_cnt8;
   end

   assign bus.sel_hit = w_sel_hit;
   assign bus.r_data  = w_sel_hit ? w_status : 32'h0;
   assign led_out     = r_led;

endmodule

// File: tb/tb_mmio_led_chain.sv
// Directed self-checking bench for mmio_led_chain: 8-channel and 6-channel instances.
module tb_mmio_led_chain;

   localparam logic [31:0] DATA_A = 32'h0000_03fc;
   localparam logic [31:0] STAT_A = 32'h0000_03f8;
   localparam logic [31:0] CTRL_A = 32'h0000_03f4;
   localparam int T0H     = 10;
   localparam int T1H     = 20;
   localparam int TBIT    = 34;
   localparam int TRESET  = 2000;
   localparam int PIX_CYC = 24 * TBIT;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [7:0]  led8;
   logic [5:0]  led6;
   int          checks = 0;
   int          failures = 0;
   int          n;
   logic [31:0] push_words [3];

   mmio_led_chain_if bus8 ();
   mmio_led_chain_if bus6 ();

   mmio_led_chain dut8 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus8),
      .led_out (led8)
   );

   mmio_led_chain #(.CHANNELS(6)) dut6 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus6),
      .led_out (led6)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic drive(input bit use6, input logic [31:0] a, input logic [31:0] d, input logic en);
      if (use6) begin
         bus6.addr = a; bus6.w_data = d; bus6.w_en = en;
      end else begin
         bus8.addr = a; bus8.w_data = d; bus8.w_en = en;
      end
   endtask

   task automatic bus_write(input bit use6, input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      drive(use6, a, d, 1'b1);
      @(negedge clock);
      drive(use6, STAT_A, 32'h0, 1'b0);
   endtask

   // Pushes push_words[0..npix-1] on consecutive cycles and checks every output cycle
   // of the frame and the latch gap against a per-cycle waveform model.
   task automatic run_stream(input bit use6, input int ch, input int npix, input string tag);
      int frame_len, last, k, p, rem, b, c, err_led, err_busy, nch;
      logic [7:0] cur_vec, exp_vec;
      logic       cur_busy, exp_busy, lvl;
      frame_len = npix * PIX_CYC;
      last      = frame_len + TRESET - 1;
      err_led   = 0;
      err_busy  = 0;
      nch       = use6 ? 6 : 8;
      for (int t = 0; t <= last + 3; t++) begin
         @(negedge clock);
         #1;
         cur_vec  = use6 ? {2'b00, led6} : led8;
         cur_busy = use6 ? bus6.r_data[0] : bus8.r_data[0];
         if (t == 2) begin
            check({tag, "_latency_low"}, {24'h0, cur_vec}, 32'h0);
         end else if (t >= 3) begin
            k = t - 3;
            if (k < frame_len) begin
               p   = k / PIX_CYC;
               rem = k % PIX_CYC;
               b   = 23 - rem / TBIT;
               c   = rem % TBIT;
               lvl = (c < (push_words[p][b] ? T1H : T0H));
               exp_vec  = (lvl && ch < nch) ? (8'h01 << ch) : 8'h00;
               exp_busy = 1'b1;
            end else begin
               exp_vec  = 8'h00;
               exp_busy = (k < last);
            end
            if (cur_vec !== exp_vec) err_led++;
            if (t > npix && k < last && cur_busy !== exp_busy) err_busy++;
            if (k == last) check({tag, "_idle_busy"}, 32'(cur_busy), 32'h0);
         end
         if (t < npix) drive(use6, DATA_A, push_words[t], 1'b1);
         else if (t == npix) drive(use6, STAT_A, 32'h0, 1'b0);
      end
      check({tag, "_led_err_cycles"}, 32'(err_led), 32'h0);
      check({tag, "_busy_err_cycles"}, 32'(err_busy), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b0, STAT_A, 32'h0, 1'b0);
      drive(1'b1, STAT_A, 32'h0, 1'b0);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check("rst_status8", bus8.r_data, 32'h0000_0002);
      check("rst_led8", {24'h0, led8}, 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      check("post_rst_status8", bus8.r_data, 32'h0000_0002);
      check("post_rst_status6", bus6.r_data, 32'h0000_0002);
      check("sel_hit_status", {31'h0, bus8.sel_hit}, 32'h1);
      drive(1'b0, 32'h0000_0100, 32'h0, 1'b0);
      #1;
      check("sel_miss_hit", {31'h0, bus8.sel_hit}, 32'h0);
      check("sel_miss_rdata", bus8.r_data, 32'h0);
      drive(1'b0, DATA_A, 32'h0, 1'b0);
      #1;
      check("sel_data_addr_hit", {31'h0, bus8.sel_hit}, 32'h0);
      drive(1'b0, STAT_A, 32'h0, 1'b0);

      // single pixel, channel 0
      push_words[0] = 32'h0080_0001;
      run_stream(1'b0, 0, 1, "single");

      // three back-to-back pixels on channel 2
      push_words[0] = 32'h02A5_A5A5;
      push_words[1] = 32'h020F_00F0;
      push_words[2] = 32'h02FF_FFFF;
      run_stream(1'b0, 2, 3, "b2b");

      // overflow with streaming disabled
      bus_write(1'b0, CTRL_A, 32'h0);
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, DATA_A, 32'h0100_0000 + 32'(i) * 32'h0011_1111, 1'b1);
         @(negedge clock);
      end
      drive(1'b0, STAT_A, 32'h0, 1'b0);
      #1;
      check("ovf_status", bus8.r_data, 32'h0000_040C);
      check("ovf_led_idle", {24'h0, led8}, 32'h0);
      bus_write(1'b0, CTRL_A, 32'h3);
      #1;
      check("ctrl_clear_status", bus8.r_data, 32'h0000_0404);
      @(negedge clock);
      #1;
      check("stream_start_status", bus8.r_data, 32'h0000_0301);
      drive(1'b0, DATA_A, 32'h0100_AAAA, 1'b1);
      @(negedge clock);
      drive(1'b0, STAT_A, 32'h0, 1'b0);
      #1;
      check("refill_full_status", bus8.r_data, 32'h0000_0405);
      repeat (814) @(negedge clock);
      drive(1'b0, DATA_A, 32'h0155_5555, 1'b1);
      @(negedge clock);
      drive(1'b0, STAT_A, 32'h0, 1'b0);
      #1;
      check("push_pop_full_status", bus8.r_data, 32'h0000_0405);
      n = 0;
      while (bus8.r_data[0] && n < 10000) begin
         @(negedge clock);
         #1;
         n++;
      end
      check("drain_cycles", 32'(n), 32'd6080);
      check("drain_status", bus8.r_data, 32'h0000_0002);

      // reset during cyc 5 of bit 10
      bus_write(1'b0, DATA_A, 32'h0000_0400);
      repeat (449) @(negedge clock);
      #1;
      check("pre_reset_led", {24'h0, led8}, 32'h0000_0001);
      reset_n = 1'b0;
      #1;
      check("async_reset_led", {24'h0, led8}, 32'h0);
      check("async_reset_status", bus8.r_data, 32'h0000_0002);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check("post_abort_status", bus8.r_data, 32'h0000_0002);
      check("post_abort_led", {24'h0, led8}, 32'h0);

      // out-of-range channel on the 6-line instance
      push_words[0] = 32'h07AB_CDEF;
      run_stream(1'b1, 7, 1, "oor");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
